// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: recovery FSM states and PC constants.
package fetch_pc_unit_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } recover_state_e;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT = 32'h0000_0004;
  localparam logic [31:0] COUNT_MAX    = 32'hFFFF_FFFF;

  // Sequential successor; relies on 32-bit modulo wrap at the top of memory.
  function automatic logic [31:0] nextSeqPc(input logic [31:0] pc);
    return pc + PC_INCREMENT;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_mispredict_recovery.sv
// Mispredict recovery FSM (RUN/RECOVER) and saturating mispredict counter.
module mispredict_recovery
  import fetch_pc_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mispredict,
  output logic        o_recover,
  output logic [31:0] o_count
);

  recover_state_e r_state;
  recover_state_e w_nextState;
  logic [31:0]    r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // RECOVER lasts one cycle unless another mispredict arrives while in it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:     w_nextState = i_mispredict ? RECOVER : RUN;
      RECOVER: w_nextState = i_mispredict ? RECOVER : RUN;
      default: w_nextState = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_mispredict && (r_count != COUNT_MAX)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_recover = (r_state == RECOVER);
  assign o_count   = r_count;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generation, F-to-D pipeline register and mispredict detection.
// Optional macro BRANCH_PREDICTION_EN enables BTB/predictor-driven fetch.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Valid_F,
  input  logic [31:0] PC_Prediction,
  input  logic        Predict_Out,
  input  logic        Branch_E,
  input  logic        Branch_Taken_E,
  input  logic        Predict_Taken_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] PC_Target_E,
  input  logic [31:0] Predict_Target_E,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic        Predict_Taken_D,
  output logic [31:0] Predict_Target_D,
  output logic        Mispredict_E,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic [31:0] Mispredict_Count
);

  logic [31:0] r_pcF;
  logic [31:0] r_pcD;
  logic        r_predictTakenD;
  logic [31:0] r_predictTargetD;
  logic [31:0] w_nextPc;
  logic        w_predictTakenF;
  logic        w_mispredict;
  logic        w_recover;
  logic [31:0] w_count;

`ifdef BRANCH_PREDICTION_EN
  assign w_predictTakenF = Valid_F & Predict_Out & ~w_recover;
  assign w_mispredict    = Branch_E &
                           ((Branch_Taken_E != Predict_Taken_E) |
                            (Branch_Taken_E & Predict_Taken_E &
                             (PC_Target_E != Predict_Target_E)));
`else
  // Without prediction every taken branch is a redirect; predictor inputs are ignored.
  logic w_unusedPredict;
  assign w_unusedPredict = Valid_F & Predict_Out & Predict_Taken_E &
                           (&Predict_Target_E) & w_recover;
  assign w_predictTakenF = 1'b0;
  assign w_mispredict    = Branch_E & Branch_Taken_E;
`endif

  // Redirect outranks stall so a resolved branch is never lost behind a hazard.
  always_comb begin
    w_nextPc = nextSeqPc(r_pcF);
    if (w_mispredict) begin
      w_nextPc = Branch_Taken_E ? PC_Target_E : nextSeqPc(PC_E);
    end else if (Stall_F) begin
      w_nextPc = r_pcF;
    end else if (w_predictTakenF) begin
      w_nextPc = PC_Prediction;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pcF <= RESET_PC;
    end else begin
      r_pcF <= w_nextPc;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pcD            <= '0;
      r_predictTakenD  <= 1'b0;
      r_predictTargetD <= '0;
    end else if (w_mispredict) begin
      r_pcD            <= '0;
      r_predictTakenD  <= 1'b0;
      r_predictTargetD <= '0;
    end else if (!Stall_D) begin
      r_pcD            <= r_pcF;
      r_predictTakenD  <= w_predictTakenF;
      r_predictTargetD <= PC_Prediction;
    end
  end

  mispredict_recovery u_recovery (
    .i_clk        (CLK),
    .i_rst_n      (RST),
    .i_mispredict (w_mispredict),
    .o_recover    (w_recover),
    .o_count      (w_count)
  );

  assign PC_F             = r_pcF;
  assign PC_D             = r_pcD;
  assign Predict_Taken_D  = r_predictTakenD;
  assign Predict_Target_D = r_predictTargetD;
  assign Mispredict_E     = w_mispredict;
  assign Flush_D          = w_mispredict;
  assign Flush_E          = w_mispredict;
  assign Mispredict_Count = w_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios then random traffic against a reference model.
module tb_fetch_pc_unit;

`ifdef BRANCH_PREDICTION_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        sf;
    logic        sd;
    logic        vf;
    logic        po;
    logic [31:0] ppred;
    logic        be;
    logic        bt;
    logic        pte;
    logic [31:0] pce;
    logic [31:0] ptgt;
    logic [31:0] ptge;
  } stim_t;

  typedef struct {
    logic [31:0] pcF;
    logic [31:0] pcD;
    logic        ptD;
    logic [31:0] tgtD;
    logic [31:0] count;
    logic        mis;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall_F, Stall_D, Valid_F, Predict_Out;
  logic [31:0] PC_Prediction;
  logic        Branch_E, Branch_Taken_E, Predict_Taken_E;
  logic [31:0] PC_E, PC_Target_E, Predict_Target_E;
  logic [31:0] PC_F, PC_D, Predict_Target_D, Mispredict_Count;
  logic        Predict_Taken_D, Mispredict_E, Flush_D, Flush_E;

  int vectors = 0;
  int miscompares = 0;
  exp_t expQ[$];

  // Reference model state: architectural values only.
  logic [31:0] mPcF, mPcD, mTgtD, mCount;
  logic        mPtD, mInRecover;

  always #5 CLK = ~CLK;

  fetch_pc_unit dut (
    .CLK(CLK), .RST(RST), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .Valid_F(Valid_F), .PC_Prediction(PC_Prediction), .Predict_Out(Predict_Out),
    .Branch_E(Branch_E), .Branch_Taken_E(Branch_Taken_E), .Predict_Taken_E(Predict_Taken_E),
    .PC_E(PC_E), .PC_Target_E(PC_Target_E), .Predict_Target_E(Predict_Target_E),
    .PC_F(PC_F), .PC_D(PC_D), .Predict_Taken_D(Predict_Taken_D),
    .Predict_Target_D(Predict_Target_D), .Mispredict_E(Mispredict_E),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Mispredict_Count(Mispredict_Count)
  );

  function automatic stim_t idle(input logic rst);
    stim_t s;
    s = '{rst: rst, sf: 0, sd: 0, vf: 0, po: 0, ppred: 0, be: 0, bt: 0, pte: 0,
          pce: 0, ptgt: 0, ptge: 0};
    return s;
  endfunction

  task automatic modelReset();
    mPcF = 32'h0; mPcD = 32'h0; mPtD = 1'b0; mTgtD = 32'h0;
    mCount = 32'h0; mInRecover = 1'b0;
  endtask

  // Drives one cycle of inputs 2 time units after a rising edge, queues the expected view, advances the model.
  task automatic applyStimulus(input stim_t s, input bit preload);
    exp_t e;
    logic ptF, mis;
    logic [31:0] nxt;
    @(posedge CLK);
    #2;
    RST = s.rst; Stall_F = s.sf; Stall_D = s.sd; Valid_F = s.vf; Predict_Out = s.po;
    PC_Prediction = s.ppred; Branch_E = s.be; Branch_Taken_E = s.bt;
    Predict_Taken_E = s.pte; PC_E = s.pce; PC_Target_E = s.ptgt; Predict_Target_E = s.ptge;
    if (!s.rst) modelReset();
    if (preload) begin
      force dut.u_recovery.r_count = 32'hFFFF_FFFE;
      #1;
      release dut.u_recovery.r_count;
      mCount = 32'hFFFF_FFFE;
    end
    ptF = PRED_EN && s.vf && s.po && !mInRecover;
    if (PRED_EN)
      mis = s.be && ((s.bt != s.pte) || (s.bt && s.pte && s.ptgt != s.ptge));
    else
      mis = s.be && s.bt;
    e = '{pcF: mPcF, pcD: mPcD, ptD: mPtD, tgtD: mTgtD, count: mCount, mis: mis};
    expQ.push_back(e);
    if (s.rst) begin
      if (mis)           nxt = s.bt ? s.ptgt : s.pce + 32'd4;
      else if (s.sf)     nxt = mPcF;
      else if (ptF)      nxt = s.ppred;
      else               nxt = mPcF + 32'd4;
      if (mis) begin
        mPcD = 0; mPtD = 0; mTgtD = 0;
      end else if (!s.sd) begin
        mPcD = mPcF; mPtD = ptF; mTgtD = s.ppred;
      end
      mPcF = nxt;
      mInRecover = mis;
      if (mis && mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: registered outputs have settled after the rising edge and inputs are stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("PC_F", PC_F, e.pcF);
        checkOutput("PC_D", PC_D, e.pcD);
        checkOutput("Predict_Taken_D", {31'b0, Predict_Taken_D}, {31'b0, e.ptD});
        checkOutput("Predict_Target_D", Predict_Target_D, e.tgtD);
        checkOutput("Mispredict_Count", Mispredict_Count, e.count);
        checkOutput("Mispredict_E", {31'b0, Mispredict_E}, {31'b0, e.mis});
        checkOutput("Flush_D", {31'b0, Flush_D}, {31'b0, e.mis});
        checkOutput("Flush_E", {31'b0, Flush_E}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    RST = 1'b0; Stall_F = 0; Stall_D = 0; Valid_F = 0; Predict_Out = 0;
    PC_Prediction = 0; Branch_E = 0; Branch_Taken_E = 0; Predict_Taken_E = 0;
    PC_E = 0; PC_Target_E = 0; Predict_Target_E = 0;
    modelReset();

    // Reset, release, first fetch advances by 4.
    applyStimulus(idle(0), 0);
    applyStimulus(idle(0), 0);
    applyStimulus(idle(1), 0);
    applyStimulus(idle(1), 0);
    applyStimulus(idle(1), 0);

    // Steer to 0x10 with a taken branch, then a BTB hit toward 0x40.
    s = idle(1); s.be = 1; s.bt = 1; s.ptgt = 32'h10;
    applyStimulus(s, 0);
    s = idle(1); s.vf = 1; s.po = 1; s.ppred = 32'h40;
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);

    // Predicted-taken branch that falls through at 0x40.
    s = idle(1); s.be = 1; s.pte = 1; s.bt = 0; s.pce = 32'h40;
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);

    // Wrong target, then a BTB hit while recovering.
    s = idle(1); s.be = 1; s.pte = 1; s.bt = 1; s.ptge = 32'h80; s.ptgt = 32'h90;
    applyStimulus(s, 0);
    s = idle(1); s.vf = 1; s.po = 1; s.ppred = 32'h400;
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);

    // Redirect beats stall; stall alone holds.
    s = idle(1); s.sf = 1; s.sd = 1; s.be = 1; s.bt = 1; s.ptgt = 32'h200;
    applyStimulus(s, 0);
    s = idle(1); s.sf = 1; s.sd = 1;
    applyStimulus(s, 0);
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);

    // Wrap at top of address space, through both the sequential and fall-through paths.
    s = idle(1); s.be = 1; s.bt = 1; s.ptgt = 32'hFFFF_FFFC;
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);
    s = idle(1); s.be = 1; s.pte = 1; s.bt = 0; s.pce = 32'hFFFF_FFFC;
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);

    // Counter saturation from a preloaded value.
    s = idle(1); s.be = 1; s.bt = 1; s.ptgt = 32'h300;
    applyStimulus(s, 1);
    applyStimulus(s, 0);
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);

    // Reset arriving with a redirect pending, then release.
    s = idle(0); s.be = 1; s.bt = 1; s.ptgt = 32'h500;
    applyStimulus(s, 0);
    applyStimulus(idle(1), 0);
    applyStimulus(idle(1), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 49) != 0);
      s.sf    = ($urandom_range(0, 3) == 0);
      s.sd    = ($urandom_range(0, 3) == 0);
      s.vf    = $urandom_range(0, 1);
      s.po    = $urandom_range(0, 1);
      s.ppred = $urandom & 32'hFFFF_FFFC;
      s.be    = ($urandom_range(0, 2) == 0);
      s.bt    = $urandom_range(0, 1);
      s.pte   = $urandom_range(0, 1);
      s.pce   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      s.ptgt  = $urandom & 32'hFFFF_FFFC;
      s.ptge  = $urandom_range(0, 1) ? s.ptgt : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(s, 0);
    end

    @(negedge CLK);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected entries left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
